spi_master_param_ctrl: RTL
==========================

// Module: spi_master_param_ctrl
// PURPOSE
//  Parametrised full-duplex SPI master: next generation of the fixed 16-bit SPI engine. Adds
//  runtime SPI mode (CPOL/CPHA), runtime clock divider, MSB/LSB-first, master-driven cs_bar,
//  programmable inter-frame gap and a valid/ready tx handshake. Sits between the UART/multiplier
//  core and the external SPI pins.
// PARAMETERS
//  DATA_WIDTH  16  bits per frame (>=2)
//  DIV_W       8   width of clk_div; sclk half-period = clk_div+1 clk cycles
//  GAP_W       6   width of gap_cycles (idle clk cycles with cs_bar high between frames)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high reset
//  tx_data     in   DATA_WIDTH  frame to transmit on mosi
//  tx_valid    in   1           tx_data valid
//  tx_ready    out  1           block can accept a frame (IDLE only)
//  clk_div     in   DIV_W       divider setting, latched at frame accept
//  cpol        in   1           sclk idle level, latched at accept (IDLE sclk tracks it live)
//  cpha        in   1           0: sample leading edge / 1: sample trailing edge; latched
//  lsb_first   in   1           1: bit 0 shifted first; latched
//  gap_cycles  in   GAP_W       inter-frame gap, latched
//  miso        in   1           serial data from slave
//  sclk        out  1           SPI clock
//  mosi        out  1           serial data to slave
//  cs_bar      out  1           chip select, active low
//  rx_data     out  DATA_WIDTH  last received frame, held until next frame completes
//  rx_valid    out  1           1-cycle pulse: rx_data updated
//  busy        out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (sync, active-high, overrides all): sclk=0, mosi=0, cs_bar=1, tx_ready=0, rx_valid=0,
//   busy=0, rx_data=0, state=IDLE. First cycle after reset: tx_ready=1, sclk=cpol.
//  All outputs registered. Reset mid-frame aborts: cs_bar=1 next cycle, no rx_valid pulse.
//  States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
//  IDLE: tx_ready=1, cs_bar=1. tx_valid&&tx_ready: latch tx_data + config, cs_bar=0, tx_ready=0,
//   busy=1, go SETUP. tx_valid outside IDLE ignored (no queueing).
//  SETUP: clk_div+1 cycles, sclk=CPOL. CPHA=0: first bit on mosi at entry.
//  XFER: 2*DATA_WIDTH half-periods, each clk_div+1 cycles. Leading edge = first toggle away from
//   CPOL. CPHA=0: sample miso on leading, shift mosi on trailing. CPHA=1: shift mosi on leading,
//   sample miso on trailing. Bit order per latched lsb_first; rx assembled in same order.
//  HOLD: clk_div+1 cycles, sclk=CPOL, mosi held. Exit: cs_bar=1, rx_data loaded, rx_valid=1 (1 cycle).
//  GAP: gap_cycles cycles, cs_bar=1. gap_cycles=0 -> straight to IDLE.
//  Frame length accept->cs_bar rise = (2*DATA_WIDTH+2)*(clk_div+1) cycles.
//  clk_div=0 -> sclk = clk/2. Config-input changes mid-frame have no effect.
//  Bit counter width $clog2(DATA_WIDTH)+1; no wrap inside a frame.
// STRUCTURE
//  spi_pkg: state_t enum {IDLE,SETUP,XFER,HOLD,GAP}; SPI_MODE0..3 {cpol,cpha} localparams.
//  Sub-module spi_sclk_gen: divider counter, emits lead_stb/trail_stb strobes and sclk; enabled
//   in XFER only, counter cleared otherwise. Top holds FSM, shift regs, bit/gap counters.
// TESTING
//  Mode0, clk_div=0, MSB-first, tx 16'hA5C3, miso loopback -> rx_data=16'hA5C3, rx_valid 1 cycle,
//   cs_bar low exactly 34 cycles.
//  Modes 1/2/3, clk_div=3, slave model sends 16'h1234 -> rx_data=16'h1234; sclk idle=cpol each mode.
//  lsb_first=1, tx 16'h0001 -> mosi high on first data bit only; slave sees 16'h8000 MSB-view.
//  Back-to-back, tx_valid held, gap_cycles=5 -> cs_bar high >=5 cycles, 2 frames, tx_ready
//   high 1 cycle between.
//  Reset asserted mid-XFER (bit 7) -> cs_bar=1, sclk=0, no rx_valid, next frame correct.
//  Change clk_div/cpha mid-frame -> current frame timing unchanged; next frame uses new values.

Source files
------------

// File: rtl/spi_master_param_ctrl_pkg.sv
// Shared types for the parametrised SPI master: FSM states, SPI mode codes
// ({cpol,cpha}) and the per-frame mode flags captured at frame accept.
package spi_master_param_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_cfg_t;

endpackage

// File: rtl/spi_master_param_ctrl_if.sv
// Frame handshake between the host core and the SPI master: tx valid/ready in,
// rx data plus one-cycle valid pulse out.
interface spi_master_param_ctrl_if #(parameter int DATA_WIDTH = 16);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);

endinterface

// File: rtl/spi_master_param_ctrl_sclk_gen.sv
// SCLK divider: each half-period lasts div+1 cycles while enabled; a strobe marks
// the cycle whose closing edge toggles sclk. Disabled, sclk rests at level.
module spi_master_param_ctrl_sclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             level,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             lead_stb,
  output logic             trail_stb
);

  logic [DIV_W-1:0] cnt;
  logic             edge_due;

  assign edge_due  = en && (cnt == div);
  // A toggle starting from the idle level moves away from it: leading edge.
  assign lead_stb  = edge_due && (sclk == level);
  assign trail_stb = edge_due && (sclk != level);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= level;
    end else if (edge_due) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param_ctrl.sv
// Full-duplex SPI master with runtime mode, divider, bit order and inter-frame gap.
// Config is captured when a frame is accepted; all outputs are registered.
module spi_master_param_ctrl
  import spi_master_param_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_W      = 8,
  parameter int GAP_W      = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  spi_master_param_ctrl_if.slave  host,
  input  logic [DIV_W-1:0]        clk_div,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic [GAP_W-1:0]        gap_cycles,
  input  logic                    miso,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs_bar,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int TMR_W = (DIV_W > GAP_W) ? DIV_W : GAP_W;

  state_t                state, next_state;
  mode_cfg_t             cfg_q;
  logic [DIV_W-1:0]      div_q;
  logic [GAP_W-1:0]      gap_q;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TMR_W-1:0]      tmr;

  logic accept, lead_stb, trail_stb, sample_stb, shift_stb;
  logic div_done, gap_done, xfer_done, sclk_level;
  logic tx_ready_d, busy_d, cs_bar_d, rx_valid_d;

  assign accept     = (state == IDLE) && host.tx_valid && host.tx_ready;
  assign sample_stb = cfg_q.cpha ? trail_stb : lead_stb;
  assign shift_stb  = cfg_q.cpha ? lead_stb  : trail_stb;
  assign div_done   = (tmr == TMR_W'(div_q));
  assign gap_done   = (tmr == TMR_W'(gap_q - 1'b1));
  // The last trailing edge closes the frame; with CPHA=1 it also takes the last sample.
  assign xfer_done  = trail_stb &&
                      ((bit_cnt + CNT_W'(cfg_q.cpha)) == CNT_W'(DATA_WIDTH));
  assign sclk_level = (state == IDLE) ? cpol : cfg_q.cpol;

  spi_master_param_ctrl_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (state == XFER),
    .level     (sclk_level),
    .div       (div_q),
    .sclk      (sclk),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      host.tx_ready <= 1'b0;
      busy          <= 1'b0;
      cs_bar        <= 1'b1;
      host.rx_valid <= 1'b0;
    end else begin
      state         <= next_state;
      host.tx_ready <= tx_ready_d;
      busy          <= busy_d;
      cs_bar        <= cs_bar_d;
      host.rx_valid <= rx_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)    next_state = SETUP;
      SETUP:   if (div_done)  next_state = XFER;
      XFER:    if (xfer_done) next_state = HOLD;
      HOLD:    if (div_done)  next_state = (gap_q == '0) ? IDLE : GAP;
      GAP:     if (gap_done)  next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_ready_d = (next_state == IDLE);
    busy_d     = (next_state != IDLE);
    cs_bar_d   = (next_state == IDLE) || (next_state == GAP);
    rx_valid_d = (state == HOLD) && (next_state != HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset || (next_state != state)) begin
      tmr <= '0;
    end else if (state inside {SETUP, HOLD, GAP}) begin
      tmr <= tmr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q        <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      mosi         <= 1'b0;
      host.rx_data <= '0;
    end else begin
      if (accept) begin
        cfg_q   <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
        div_q   <= clk_div;
        gap_q   <= gap_cycles;
        bit_cnt <= '0;
        // CPHA=0 presents the first bit before the first edge; CPHA=1 waits for it.
        if (!cpha) begin
          mosi  <= lsb_first ? host.tx_data[0] : host.tx_data[DATA_WIDTH-1];
          tx_sr <= lsb_first ? (host.tx_data >> 1) : (host.tx_data << 1);
        end else begin
          tx_sr <= host.tx_data;
        end
      end else if (state == XFER) begin
        if (shift_stb && (bit_cnt != CNT_W'(DATA_WIDTH))) begin
          mosi  <= cfg_q.lsb_first ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
          tx_sr <= cfg_q.lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
        end
        if (sample_stb) begin
          rx_sr   <= cfg_q.lsb_first ? {miso, rx_sr[DATA_WIDTH-1:1]}
                                     : {rx_sr[DATA_WIDTH-2:0], miso};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (rx_valid_d) begin
        host.rx_data <= rx_sr;
      end
    end
  end

endmodule
